sonic_reg_req: RTL
==================

SONIC_REG_REQ -- requirements
Module: sonic_reg_req

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the read-response timeout in clk_in cycles (legal 8..65535).
REQ-002 clk_in  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 rstn  input  1  reset; synchronous and active-low, sampled on the rising edge of clk_in.
REQ-004 req_valid / req_ready  input / output  1 / 1  BAR2/3 request handshake from the RX TLP decoder.
REQ-005 req_is_wr  input  1  1 = register write (MWr), 0 = register read (MRd).
REQ-006 req_addr, req_wrdata, req_tag  input  8 / 32 / 8  byte address, write data, and completion tag of the request.
REQ-007 sel_ep_reg, reg_wr_ena, reg_rd_ena  output  1 each  target-side select, write pulse, and read pulse.
REQ-008 reg_wr_addr, reg_rd_addr, reg_wr_data  output  8 / 8 / 32  target address and data buses.
REQ-009 reg_rd_data, reg_rd_data_valid  input  32 / 1  target read data and its one-cycle valid pulse.
REQ-010 cpl_valid / cpl_ready  output / input  1 / 1  read-completion handshake to the TX completion generator.
REQ-011 cpl_data, cpl_tag, cpl_err  output  32 / 8 / 1  completion payload, echoed tag, and timeout flag.
REQ-012 timeout_cnt  output  8  saturating count of timed-out reads.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WR, RD_ISSUE, RD_WAIT, and CPL.
REQ-014 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle with req_valid && req_ready.
REQ-015 On acceptance, the block SHALL register addr as {req_addr[7:2],2'b00}, together with wrdata and tag.
REQ-016 On acceptance it SHALL go to WR if req_is_wr=1, else to RD_ISSUE.
REQ-017 WR: reg_wr_ena and sel_ep_reg SHALL be 1 for exactly one cycle, with reg_wr_addr and reg_wr_data valid that cycle; next state IDLE.
REQ-018 A write SHALL therefore occupy 2 cycles, and the next request SHALL be accepted no earlier than 2 cycles after the previous acceptance.
REQ-019 RD_ISSUE: reg_rd_ena and sel_ep_reg SHALL be 1 for exactly one cycle; next state RD_WAIT.
REQ-020 reg_rd_addr SHALL hold the captured address from RD_ISSUE through the exit from RD_WAIT, because the target samples the address continuously.
REQ-021 RD_WAIT: when reg_rd_data_valid=1, the block SHALL capture reg_rd_data into cpl_data, set cpl_err=0, and go to CPL.
REQ-022 A reg_rd_data_valid arriving on the same cycle as the RD_ISSUE pulse SHALL be ignored.
REQ-023 reg_rd_data_valid SHALL be ignored in IDLE, WR, and CPL; stale pulses SHALL cause no state change.
REQ-024 CPL: cpl_valid SHALL be 1, with cpl_data, cpl_tag, and cpl_err held stable until cpl_ready=1.
REQ-025 On the cpl_valid && cpl_ready cycle the block SHALL go to IDLE, with cpl_valid=0 on the next cycle.
REQ-026 The block SHALL support only one outstanding request; no new request SHALL be accepted until CPL completes or WR finishes.
REQ-027 reg_wr_addr and reg_wr_data SHALL hold their last values when idle.
REQ-028 reg_wr_ena and reg_rd_ena SHALL never be 1 on the same cycle.

Reset
REQ-029 With rstn=0 at a clock edge, the state SHALL be IDLE and req_ready SHALL be 1.
REQ-030 With rstn=0 at a clock edge, sel_ep_reg, reg_wr_ena, reg_rd_ena, cpl_valid, and cpl_err SHALL be 0.
REQ-031 With rstn=0 at a clock edge, all address and data outputs, cpl_tag, timeout_cnt, and the timeout counter SHALL be 0.
REQ-032 Reset asserted mid-transaction (WR, RD_WAIT, CPL) SHALL abandon the transaction with no completion issued.
REQ-033 A reg_rd_data_valid pulse arriving after reset releases SHALL be ignored, per REQ-023.

Configuration
REQ-034 The macro SONIC_REG_TIMEOUT_EN SHALL control the read-response timeout feature.
REQ-035 When SONIC_REG_TIMEOUT_EN is defined, a 16-bit counter SHALL clear on entry to RD_WAIT and increment each cycle in RD_WAIT.
REQ-036 When that counter reaches TIMEOUT_CYCLES-1 without valid, the block SHALL set cpl_data=32'hDEAD_BEEF and cpl_err=1, increment timeout_cnt (saturating at 8'hFF), and go to CPL.
REQ-037 If valid and timeout coincide on the same cycle, valid SHALL win, giving cpl_err=0 and real data.
REQ-038 When SONIC_REG_TIMEOUT_EN is undefined, RD_WAIT SHALL wait indefinitely, cpl_err SHALL be tied to 0, timeout_cnt SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-039 Write: req addr 8'h13, wrdata 32'hA5A5_0001 -> exactly one reg_wr_ena pulse with reg_wr_addr=8'h10 and data A5A5_0001, no cpl_valid, and req_ready back at 1 two cycles after acceptance.
REQ-040 Read with valid returned 4 cycles after the reg_rd_ena pulse (reg_rd_data=32'h1234_5678), tag 8'h2C -> cpl_valid with data 1234_5678, tag 2C, cpl_err=0, and reg_rd_addr stable throughout.
REQ-041 Backpressure: cpl_ready held 0 for 10 cycles -> cpl_* stable, req_ready=0 throughout, and release to IDLE one cycle after cpl_ready=1.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=8): no valid returned -> cpl_data=DEAD_BEEF, cpl_err=1, timeout_cnt=1.
REQ-043 Timeout edge case (macro on, TIMEOUT_CYCLES=8): valid on the exact expiry cycle -> real data with cpl_err=0.
REQ-044 Reset in RD_WAIT, then a late reg_rd_data_valid pulse -> no cpl_valid, and a back-to-back write then read proceed normally.

Source files
------------

// File: rtl/sonic_reg_req_if.sv
// BAR2/3 register request and read-completion handshakes between the
// TLP path (master) and sonic_reg_req (slave).
interface sonic_reg_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_wrdata;
    logic [7:0]  req_tag;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [31:0] cpl_data;
    logic [7:0]  cpl_tag;
    logic        cpl_err;

    modport master (
        output req_valid, req_is_wr, req_addr, req_wrdata, req_tag,
        output cpl_ready,
        input  req_ready, cpl_valid, cpl_data, cpl_tag, cpl_err
    );

    modport slave (
        input  req_valid, req_is_wr, req_addr, req_wrdata, req_tag,
        input  cpl_ready,
        output req_ready, cpl_valid, cpl_data, cpl_tag, cpl_err
    );
endinterface

// File: rtl/sonic_reg_req.sv
// Single-outstanding BAR2/3 register request bridge with read completions.
// Read-response timeout is built only when SONIC_REG_TIMEOUT_EN is defined.
module sonic_reg_req #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_in,
    input  logic        rstn,
    sonic_reg_req_if.slave bus,
    output logic        sel_ep_reg,
    output logic        reg_wr_ena,
    output logic        reg_rd_ena,
    output logic [7:0]  reg_wr_addr,
    output logic [7:0]  reg_rd_addr,
    output logic [31:0] reg_wr_data,
    input  logic [31:0] reg_rd_data,
    input  logic        reg_rd_data_valid,
    output logic [7:0]  timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE, WR, RD_ISSUE, RD_WAIT, CPL
    } state_t;

    state_t     state;
    logic       accept;
    logic [7:0] addr_al;

    assign accept  = bus.req_valid && bus.req_ready;
    assign addr_al = {bus.req_addr[7:2], 2'b00};

`ifdef SONIC_REG_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic [7:0]  to_cnt;
    logic        expire;

    assign expire      = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_cnt = to_cnt;
`else
    // Constant zero across the legal TIMEOUT_CYCLES range.
    assign timeout_cnt = 8'(TIMEOUT_CYCLES >> 16);
    assign bus.cpl_err = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            sel_ep_reg    <= 1'b0;
            reg_wr_ena    <= 1'b0;
            reg_rd_ena    <= 1'b0;
            reg_wr_addr   <= '0;
            reg_rd_addr   <= '0;
            reg_wr_data   <= '0;
            bus.cpl_valid <= 1'b0;
            bus.cpl_data  <= '0;
            bus.cpl_tag   <= '0;
`ifdef SONIC_REG_TIMEOUT_EN
            bus.cpl_err   <= 1'b0;
            wait_cnt      <= '0;
            to_cnt        <= '0;
`endif
        end else begin
            sel_ep_reg <= 1'b0;
            reg_wr_ena <= 1'b0;
            reg_rd_ena <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        sel_ep_reg    <= 1'b1;
                        bus.cpl_tag   <= bus.req_tag;
                        if (bus.req_is_wr) begin
                            state       <= WR;
                            reg_wr_ena  <= 1'b1;
                            reg_wr_addr <= addr_al;
                            reg_wr_data <= bus.req_wrdata;
                        end else begin
                            state       <= RD_ISSUE;
                            reg_rd_ena  <= 1'b1;
                            reg_rd_addr <= addr_al;
                        end
                    end
                end
                WR: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                RD_ISSUE: begin
                    // Valid seen alongside the issue pulse is stale.
                    state <= RD_WAIT;
`ifdef SONIC_REG_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                RD_WAIT: begin
                    if (reg_rd_data_valid) begin
                        state         <= CPL;
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_data  <= reg_rd_data;
`ifdef SONIC_REG_TIMEOUT_EN
                        bus.cpl_err   <= 1'b0;
                    end else if (expire) begin
                        state         <= CPL;
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_data  <= 32'hDEAD_BEEF;
                        bus.cpl_err   <= 1'b1;
                        if (to_cnt != 8'hFF)
                            to_cnt <= to_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                CPL: begin
                    if (bus.cpl_ready) begin
                        state         <= IDLE;
                        bus.cpl_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
